// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory controller: frame sizing and the
// controller state encoding.
package spi_pkg;

  localparam int WORD_BITS = 8;
  localparam int CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SEND   = 3'd4,
    WRITE_GET   = 3'd5,
    WRITE_STORE = 3'd6,
    DONE        = 3'd7
  } state_t;

  // States in which the edge counter is allowed to hold a running count.
  function automatic logic is_counting(input state_t s);
    case (s)
      GET_ADDR, READ_SEND, WRITE_GET: is_counting = 1'b1;
      default:                        is_counting = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_edge_counter.sv
// Saturating SCLK-edge counter for one frame phase; done flags the edge that
// completes the phase.
module spi_edge_counter #(
  parameter int WORD_BITS = spi_pkg::WORD_BITS,
  parameter int CNT_W     = spi_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_BITS);

  logic [CNT_W-1:0] r_count;

  // Count register: clear wins over increment, and it saturates at WORD_BITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != FULL)) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;
  assign done  = inc && !clr && (r_count == LAST);

endmodule

// File: rtl/spi_fsm_controller.sv
// Sequencing FSM for the SPI memory: address latch, shift-register load,
// data-memory write and MISO enable, all decoded from registered state.
module spi_fsm_controller
  import spi_pkg::*;
#(
  parameter int WORD_BITS = spi_pkg::WORD_BITS,
  parameter int CNT_W     = spi_pkg::CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       sclk_pe,
  input  logic       sclk_ne,
  input  logic       rw_bit,
  output logic       addr_we,
  output logic       sr_we,
  output logic       dm_we,
  output logic       miso_buff,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_BITS);

  state_t           r_state;
  state_t           w_next;
  logic             r_addr_we;
  logic             r_sr_we;
  logic             r_dm_we;
  logic             r_miso_buff;
  logic             w_clr;
  logic             w_inc;
  logic             w_done;
  logic [CNT_W-1:0] w_count;

  spi_edge_counter #(
    .WORD_BITS(WORD_BITS),
    .CNT_W    (CNT_W)
  ) u_edge_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .inc  (w_inc),
    .count(w_count),
    .done (w_done)
  );

  // Next-state logic; cs=1 aborts from every non-idle state before anything else.
  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    w_clr  = cs || !is_counting(r_state);
    case (r_state)
      IDLE: begin
        if (!cs) w_next = GET_ADDR;
        else     w_next = IDLE;
      end
      GET_ADDR: begin
        w_inc = sclk_pe && (w_count != FULL);
        if (cs)          w_next = IDLE;
        else if (w_done) w_next = GOT_ADDR;
        else             w_next = GET_ADDR;
      end
      GOT_ADDR: begin
        if (cs)          w_next = IDLE;
        else if (rw_bit) w_next = READ_LOAD;
        else             w_next = WRITE_GET;
      end
      READ_LOAD: begin
        if (cs) w_next = IDLE;
        else    w_next = READ_SEND;
      end
      READ_SEND: begin
        w_inc = sclk_ne && (w_count != FULL);
        if (cs)          w_next = IDLE;
        else if (w_done) w_next = DONE;
        else             w_next = READ_SEND;
      end
      WRITE_GET: begin
        w_inc = sclk_pe && (w_count != FULL);
        if (cs)          w_next = IDLE;
        else if (w_done) w_next = WRITE_STORE;
        else             w_next = WRITE_GET;
      end
      WRITE_STORE: begin
        if (cs) w_next = IDLE;
        else    w_next = DONE;
      end
      DONE: begin
        if (cs) w_next = IDLE;
        else    w_next = DONE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they line up cycle-for-cycle with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr_we   <= 1'b0;
      r_sr_we     <= 1'b0;
      r_dm_we     <= 1'b0;
      r_miso_buff <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_addr_we   <= (w_next == GOT_ADDR);
      r_sr_we     <= (w_next == READ_LOAD);
      r_dm_we     <= (w_next == WRITE_STORE);
      r_miso_buff <= (w_next == READ_SEND);
    end
  end

  assign addr_we   = r_addr_we;
  assign sr_we     = r_sr_we;
  assign dm_we     = r_dm_we;
  assign miso_buff = r_miso_buff;
  assign state     = r_state;

endmodule

// File: tb/tb_spi_fsm_controller.sv
// Directed bench for spi_fsm_controller: strobe events are scoreboarded by a
// negedge monitor, state/MISO milestones are checked inline.
module tb_spi_fsm_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic       sclk_pe;
  logic       sclk_ne;
  logic       rw_bit;
  logic       addr_we;
  logic       sr_we;
  logic       dm_we;
  logic       miso_buff;
  logic [2:0] state;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         ecyc;
    logic [2:0] strobes;   // {addr_we, sr_we, dm_we}
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spi_fsm_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .sclk_pe  (sclk_pe),
    .sclk_ne  (sclk_ne),
    .rw_bit   (rw_bit),
    .addr_we  (addr_we),
    .sr_we    (sr_we),
    .dm_we    (dm_we),
    .miso_buff(miso_buff),
    .state    (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle edge pulse followed by one quiet cycle.
  task automatic pulse(input logic pe, input logic ne);
    sclk_pe = pe;
    sclk_ne = ne;
    tick();
    sclk_pe = 1'b0;
    sclk_ne = 1'b0;
    tick();
  endtask

  task automatic push_ev(input int ecyc, input logic [2:0] strobes);
    ev_t e;
    e.ecyc    = ecyc;
    e.strobes = strobes;
    exp_q.push_back(e);
  endtask

  // cs low, then a full address phase; queues addr_we (and sr_we for reads).
  task automatic addr_phase(input logic rw);
    rw_bit = rw;
    cs     = 1'b0;
    tick();
    chk("get_addr_entry", 32'(state), 32'd1);
    repeat (7) pulse(1'b1, 1'b0);
    push_ev(cyc + 1, 3'b100);
    if (rw) push_ev(cyc + 2, 3'b010);
    pulse(1'b1, 1'b0);
  endtask

  task automatic data_write_phase();
    repeat (7) pulse(1'b1, 1'b0);
    chk("write_get_before_last", 32'(state), 32'd5);
    push_ev(cyc + 1, 3'b001);
    pulse(1'b1, 1'b0);
  endtask

  // Scoreboard monitor: every strobe cycle must match the next queued event.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (addr_we | sr_we | dm_we)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'({addr_we, sr_we, dm_we}), 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(e.ecyc));
        chk("strobe_value", 32'({addr_we, sr_we, dm_we}), 32'(e.strobes));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    cs      = 1'b1;
    sclk_pe = 1'b0;
    sclk_ne = 1'b0;
    rw_bit  = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 32'({addr_we, sr_we, dm_we, miso_buff, state}), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_after_reset", 32'(state), 32'd0);

    // Write transaction followed by DONE hold.
    addr_phase(1'b0);
    chk("write_get_entry", 32'(state), 32'd5);
    chk("write_no_miso", 32'(miso_buff), 32'd0);
    data_write_phase();
    chk("write_done", 32'(state), 32'd7);
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b0);
      chk("done_hold_state", 32'(state), 32'd7);
      chk("done_hold_dm_we", 32'(dm_we), 32'd0);
    end
    cs = 1'b1;
    tick();
    chk("done_to_idle", 32'(state), 32'd0);

    // Read transaction: rising edges ignored, coincident edges count once.
    addr_phase(1'b1);
    tick();
    chk("read_send_entry", 32'(state), 32'd4);
    chk("read_send_miso", 32'(miso_buff), 32'd1);
    for (int i = 0; i < 8; i++) begin
      pulse(1'b1, 1'b0);
      chk("read_pe_ignored", 32'(state), 32'd4);
      pulse(1'(i % 2), 1'b1);
      if (i < 7) begin
        chk("read_send_hold", 32'(state), 32'd4);
        chk("read_miso_hold", 32'(miso_buff), 32'd1);
      end else begin
        chk("read_done", 32'(state), 32'd7);
        chk("read_done_miso", 32'(miso_buff), 32'd0);
      end
    end
    cs = 1'b1;
    tick();
    chk("read_to_idle", 32'(state), 32'd0);

    // Abort after three data edges of a write.
    addr_phase(1'b0);
    repeat (3) pulse(1'b1, 1'b0);
    chk("abort_pre_state", 32'(state), 32'd5);
    cs = 1'b1;
    tick();
    chk("abort_idle", 32'(state), 32'd0);
    repeat (4) tick();
    chk("abort_no_dm_we", 32'(dm_we), 32'd0);

    // Restart: wrong edges filtered and the count starts from zero.
    rw_bit = 1'b0;
    cs     = 1'b0;
    tick();
    chk("restart_get_addr", 32'(state), 32'd1);
    repeat (10) pulse(1'b0, 1'b1);
    repeat (7) pulse(1'b1, 1'b0);
    chk("filter_still_get_addr", 32'(state), 32'd1);
    push_ev(cyc + 1, 3'b100);
    sclk_pe = 1'b1;
    tick();
    sclk_pe = 1'b0;
    chk("filter_got_addr", 32'(state), 32'd2);
    tick();
    chk("filter_write_get", 32'(state), 32'd5);

    // Asynchronous reset mid-write with five data edges counted.
    repeat (5) pulse(1'b1, 1'b0);
    chk("pre_reset_state", 32'(state), 32'd5);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'({addr_we, sr_we, dm_we, miso_buff, state}), 32'd0);
    cs = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_after_release", 32'(state), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
